kamikaze_imem_loader: RTL
=========================

Name: kamikaze_imem_loader

Overview:
- Instruction-memory responder serving the fetch stage's word-aligned instruction requests, with one-cycle registered read latency.
- Also owns program load: a byte-stream loader port fills the RAM after reset.
- Holds the core in reset (cpu_rst_o low) until the load completes, then serves fetch reads.
- Sits between the core's instruction port and the boot/debug byte source.

Parameters:
- DEPTH_WORDS, 1024, RAM depth in 32-bit words (power of two).
- AW, clog2(DEPTH_WORDS), word-address width.
- NOP_WORD, 32'h0000_0013, value returned for out-of-range or not-yet-running reads.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-low reset.
- im_addr_i  in  32  fetch byte address. Bits [1:0] are ignored.
- im_data_o  out  32  instruction word, registered.
- ld_valid_i  in  1  loader byte valid.
- ld_ready_o  out  1  loader ready to accept a byte.
- ld_byte_i  in  8  loader byte, little-endian stream starting at address 0.
- ld_last_i  in  1  marks the final byte; qualified by ld_valid_i & ld_ready_o.
- ld_start_i  in  1  reload request (used only with the optional feature).
- cpu_rst_o  out  1  active-low core reset; low while loading.
- load_done_o  out  1  high in RUN.
- load_err_o  out  1  sticky overflow flag.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-low; all state is sampled on the posedge when rst_i is 0.
- Reset values:
  - state = LOAD, byte counter = 0, word address = 0, assembly register = 0.
  - im_data_o = NOP_WORD, ld_ready_o = 0, cpu_rst_o = 0, load_done_o = 0, load_err_o = 0.
  - RAM contents are not cleared.
- LOAD state:
  - ld_ready_o = 1 from the first cycle after reset deassertion.
  - A byte is accepted when ld_valid_i & ld_ready_o. It goes into assembly lane byte_cnt[1:0]; byte_cnt then increments, 2 bits wrapping.
  - On the 4th accepted byte the assembled word is written to RAM at waddr in the same cycle, waddr increments, and the assembly register clears to 0.
  - On an accepted byte with ld_last_i: ld_ready_o drops the next cycle and the state goes to FLUSH.
  - im_data_o stays NOP_WORD; cpu_rst_o stays 0.
- FLUSH state (one cycle):
  - If byte_cnt != 0, write the partial word. Unfilled upper bytes are 0.
  - Then go to RUN.
- RUN state:
  - load_done_o = 1 and cpu_rst_o = 1, both registered, so the core leaves reset on the first RUN cycle.
  - Every cycle, im_data_o <= RAM[im_addr_i[AW+1:2]] if im_addr_i[31:AW+2] == 0, else NOP_WORD.
  - Latency is exactly 1 cycle, no stall. This matches the fetch unit, which issues the address one cycle ahead of its PC and consumes data the next cycle.
  - ld_ready_o = 0; loader bytes are ignored.
- Overflow:
  - An accepted byte when waddr == DEPTH_WORDS (all words written) is dropped and sets load_err_o.
  - load_err_o stays set until reset; the load still completes on ld_last_i.
  - waddr saturates and does not wrap.
- Simultaneous events:
  - ld_last_i on a 4th byte: the full word is written that cycle and FLUSH writes nothing.
  - Reset mid-load: the load restarts at address 0 and previously written words stay in RAM.
  - ld_valid_i without ld_ready_o: ignored.
- Read/write collision: impossible, since writes only occur in LOAD/FLUSH and reads are only meaningful in RUN.

Optional Feature:
- Macro: KAMIKAZE_IMEM_RELOAD_EN.
- With the macro defined: in RUN, ld_start_i = 1 for one cycle returns to LOAD on the next edge.
  - cpu_rst_o and load_done_o drop that same edge.
  - byte_cnt and waddr clear; load_err_o clears.
  - im_data_o returns NOP_WORD from the next cycle.
- Without the macro: ld_start_i is ignored, and only rst_i can restart a load.

Decomposition:
- Shared package kamikaze_pkg:
  - NOP_WORD constant.
  - imem state encoding LOAD=2'd0, FLUSH=2'd1, RUN=2'd2.
  - Width constant XLEN=32.
- Sub-module kamikaze_imem_ram: simple dual-port synchronous RAM with one write port and one registered read port, DEPTH_WORDS x 32. The FSM and byte assembly stay in the top.

Test Plan:
- Load bytes 13 05 10 00 97 00 00 00 with last on the 8th -> RAM[0]=32'h0010_0513, RAM[1]=32'h0000_0097; cpu_rst_o rises 2 cycles after the last byte; im_addr_i=4 -> im_data_o=32'h0000_0097 the next cycle.
- Load 6 bytes 01 45 82 80 AA BB with last on the 6th -> RAM[1]=32'h0000_BBAA via FLUSH; im_addr_i=6 reads RAM[1] (bits [1:0] ignored).
- In RUN, im_addr_i=32'h0001_0000 with DEPTH_WORDS=1024 -> im_data_o=32'h0000_0013.
- DEPTH_WORDS=4, send 20 bytes -> load_err_o=1 after byte 17; RAM[0..3] hold bytes 1-16; RUN reached after byte 20.
- Assert rst_i=0 after 3 bytes, then reload 4 bytes DE AD BE EF -> RAM[0]=32'hEFBE_ADDE; ld_ready_o=0 during reset.
- With KAMIKAZE_IMEM_RELOAD_EN: pulse ld_start_i in RUN -> next cycle cpu_rst_o=0, load_done_o=0, ld_ready_o=1; without the macro, no change.

Source files
------------

// File: rtl/kamikaze_pkg.sv
// Shared constants and types for the kamikaze instruction-memory loader.
package kamikaze_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      FLUSH = 2'd1,
      RUN   = 2'd2
   } imem_state_e;

endpackage

// File: rtl/kamikaze_imem_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module kamikaze_imem_ram
   import kamikaze_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic            clk_i,
   input  logic            we_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [AW-1:0]   raddr_i,
   output logic [XLEN-1:0] rdata_o
);

   logic [XLEN-1:0] mem_q [DEPTH_WORDS];
   logic [XLEN-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/kamikaze_imem_loader.sv
// Instruction memory with byte-stream program loader; holds the core in reset until loaded.
// Optional macro KAMIKAZE_IMEM_RELOAD_EN: ld_start_i in RUN restarts a load.
module kamikaze_imem_loader
   import kamikaze_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] im_addr_i,
   output logic [XLEN-1:0] im_data_o,
   input  logic            ld_valid_i,
   output logic            ld_ready_o,
   input  logic [7:0]      ld_byte_i,
   input  logic            ld_last_i,
   input  logic            ld_start_i,
   output logic            cpu_rst_o,
   output logic            load_done_o,
   output logic            load_err_o
);

   imem_state_e     state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [AW:0]     waddr_q, waddr_d;
   logic [XLEN-1:0] asm_q, asm_d;
   logic            ready_q, ready_d;
   logic            done_q, done_d;
   logic            cpu_rst_q, cpu_rst_d;
   logic            err_q, err_d;
   logic            nop_q, nop_d;

   logic            we_c;
   logic [XLEN-1:0] wdata_c;
   logic [XLEN-1:0] rdata_c;
   logic            accept_c;
   logic            in_range_c;
   logic            unused_ok_c;

   assign accept_c   = ld_valid_i & ready_q;
   assign in_range_c = (im_addr_i[XLEN-1:AW+2] == '0);

`ifdef KAMIKAZE_IMEM_RELOAD_EN
   assign unused_ok_c = &{1'b0, im_addr_i[1:0]};
`else
   assign unused_ok_c = &{1'b0, im_addr_i[1:0], ld_start_i};
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      waddr_d   = waddr_q;
      asm_d     = asm_q;
      ready_d   = 1'b0;
      done_d    = 1'b0;
      cpu_rst_d = 1'b0;
      err_d     = err_q;
      nop_d     = 1'b1;
      we_c      = 1'b0;
      wdata_c   = asm_q;

      unique case (state_q)
         LOAD: begin
            ready_d = 1'b1;
            if (accept_c) begin
               // Bytes past the last RAM word are dropped and flagged.
               if (waddr_q == (AW+1)'(DEPTH_WORDS)) begin
                  err_d = 1'b1;
               end else begin
                  if (cnt_q == 2'd3) begin
                     we_c    = 1'b1;
                     wdata_c = {ld_byte_i, asm_q[23:0]};
                     waddr_d = waddr_q + (AW+1)'(1);
                     asm_d   = '0;
                  end else begin
                     asm_d[{cnt_q, 3'b000} +: 8] = ld_byte_i;
                  end
                  cnt_d = cnt_q + 2'd1;
               end
               if (ld_last_i) begin
                  state_d = FLUSH;
                  ready_d = 1'b0;
               end
            end
         end
         FLUSH: begin
            we_c      = (cnt_q != 2'd0);
            cnt_d     = 2'd0;
            asm_d     = '0;
            state_d   = RUN;
            done_d    = 1'b1;
            cpu_rst_d = 1'b1;
         end
         RUN: begin
            done_d    = 1'b1;
            cpu_rst_d = 1'b1;
            nop_d     = ~in_range_c;
`ifdef KAMIKAZE_IMEM_RELOAD_EN
            if (ld_start_i) begin
               state_d   = LOAD;
               cnt_d     = 2'd0;
               waddr_d   = '0;
               asm_d     = '0;
               err_d     = 1'b0;
               done_d    = 1'b0;
               cpu_rst_d = 1'b0;
               ready_d   = 1'b1;
               nop_d     = 1'b1;
            end
`endif
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= LOAD;
         cnt_q     <= 2'd0;
         waddr_q   <= '0;
         asm_q     <= '0;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
         cpu_rst_q <= 1'b0;
         err_q     <= 1'b0;
         nop_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         waddr_q   <= waddr_d;
         asm_q     <= asm_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         cpu_rst_q <= cpu_rst_d;
         err_q     <= err_d;
         nop_q     <= nop_d;
      end
   end

   kamikaze_imem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (we_c),
      .waddr_i (waddr_q[AW-1:0]),
      .wdata_i (wdata_c),
      .raddr_i (im_addr_i[AW+1:2]),
      .rdata_o (rdata_c)
   );

   // Read data and the NOP select are both flopped on the same edge: one-cycle latency.
   assign im_data_o   = nop_q ? NOP_WORD : rdata_c;
   assign ld_ready_o  = ready_q;
   assign cpu_rst_o   = cpu_rst_q;
   assign load_done_o = done_q;
   assign load_err_o  = err_q;

endmodule
